// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller.
//   state_e : controller state encodings (visible on state_o)
//   op_e    : menu operation codes
//   err_e   : error codes reported on err_code
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PIN   = 3'd1,
        ST_MENU  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_EJECT = 3'd4,
        ST_LOCK  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_BAL  = 2'b00,
        OP_WDR  = 2'b01,
        OP_DEP  = 2'b10,
        OP_EXIT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TMO      = 2'b01,
        ERR_AMT      = 2'b10,
        ERR_OVF_LOCK = 2'b11
    } err_e;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Bundle of the session controller's front-end, balance-store and timer
// signals.
//   master : drives card/keypad strobes, balance_in and timeout; observes the rest
//   slave  : the session controller itself
interface atm_session_ctrl_if #(
    parameter int BAL_W = 16
);
    logic             card_in;
    logic             pin_valid;
    logic             pin_ok;
    logic             op_valid;
    logic [1:0]       op_code;
    logic [BAL_W-1:0] amount;
    logic [BAL_W-1:0] balance_in;
    logic             timeout;
    logic             timer_clr;
    logic [2:0]       state_o;
    logic             balance_we;
    logic [BAL_W-1:0] balance_out;
    logic             done;
    logic [1:0]       err_code;
    logic             eject;
    logic             card_locked;

    modport master (
        output card_in, pin_valid, pin_ok, op_valid, op_code, amount,
               balance_in, timeout,
        input  timer_clr, state_o, balance_we, balance_out, done, err_code,
               eject, card_locked
    );

    modport slave (
        input  card_in, pin_valid, pin_ok, op_valid, op_code, amount,
               balance_in, timeout,
        output timer_clr, state_o, balance_we, balance_out, done, err_code,
               eject, card_locked
    );
endinterface

// File: rtl/atm_txn_calc.sv
// Combinational transaction evaluator.
//   op_i, amount_i, balance_i : latched operation, latched amount, live balance
//   new_balance_o             : resulting balance (unchanged balance on query/error)
//   write_ok_o                : balance store should be written
//   err_o                     : outcome code
module atm_txn_calc
    import atm_pkg::*;
#(
    parameter int BAL_W = 16
) (
    input  op_e              op_i,
    input  logic [BAL_W-1:0] amount_i,
    input  logic [BAL_W-1:0] balance_i,
    output logic [BAL_W-1:0] new_balance_o,
    output logic             write_ok_o,
    output err_e             err_o
);

    logic [BAL_W:0] sum;

    always_comb begin
        sum           = {1'b0, balance_i} + {1'b0, amount_i};
        new_balance_o = balance_i;
        write_ok_o    = 1'b0;
        err_o         = ERR_NONE;
        case (op_i)
            OP_WDR: begin
                if ((amount_i == '0) || (amount_i > balance_i)) begin
                    err_o = ERR_AMT;
                end else begin
                    new_balance_o = balance_i - amount_i;
                    write_ok_o    = 1'b1;
                end
            end
            OP_DEP: begin
                if (amount_i == '0) begin
                    err_o = ERR_AMT;
                end else if (sum[BAL_W]) begin
                    err_o = ERR_OVF_LOCK;
                end else begin
                    new_balance_o = sum[BAL_W-1:0];
                    write_ok_o    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insertion, PIN entry with retry lockout,
// menu selection and single-cycle transaction execution. Restarts the
// inactivity timer through timer_clr and reacts to its timeout pulse.
//   clk, rst : system clock, asynchronous active-low reset
//   sif      : slave side of atm_session_ctrl_if (all outputs registered)
//
// state | meaning
// IDLE  | no card, waiting for insertion
// PIN   | card present, waiting for PIN entry
// MENU  | authenticated, waiting for an operation
// EXEC  | one-cycle execution of the latched operation
// EJECT | returning card, waiting for removal
// LOCK  | card retained after too many wrong PINs, left only by reset
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int MAX_TRIES = 3,
    parameter int BAL_W     = 16
) (
    input logic              clk,
    input logic              rst,
    atm_session_ctrl_if.slave sif
);

    state_e           state_q;
    logic [2:0]       tries_q;
    op_e              op_q;
    logic [BAL_W-1:0] amt_q;
    logic             timer_clr_q;
    logic             balance_we_q;
    logic [BAL_W-1:0] balance_out_q;
    logic             done_q;
    err_e             err_q;
    logic             eject_q;
    logic             locked_q;

    logic [BAL_W-1:0] calc_balance;
    logic             calc_write_ok;
    err_e             calc_err;

    // Operates on the latched op/amount against the live balance, so the
    // result registered in EXEC reflects the store's value at that cycle.
    atm_txn_calc #(.BAL_W(BAL_W)) u_calc (
        .op_i          (op_q),
        .amount_i      (amt_q),
        .balance_i     (sif.balance_in),
        .new_balance_o (calc_balance),
        .write_ok_o    (calc_write_ok),
        .err_o         (calc_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            tries_q       <= '0;
            op_q          <= OP_BAL;
            amt_q         <= '0;
            timer_clr_q   <= 1'b0;
            balance_we_q  <= 1'b0;
            balance_out_q <= '0;
            done_q        <= 1'b0;
            err_q         <= ERR_NONE;
            eject_q       <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            // Pulse outputs; balance_out is only meaningful alongside done.
            timer_clr_q   <= 1'b0;
            balance_we_q  <= 1'b0;
            done_q        <= 1'b0;
            balance_out_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sif.card_in) begin
                        state_q     <= ST_PIN;
                        timer_clr_q <= 1'b1;
                        tries_q     <= '0;
                        err_q       <= ERR_NONE;
                    end
                end
                ST_PIN: begin
                    if (!sif.card_in) begin
                        state_q <= ST_IDLE;
                        err_q   <= ERR_NONE;
                    end else if (sif.timeout) begin
                        state_q <= ST_EJECT;
                        err_q   <= ERR_TMO;
                        eject_q <= 1'b1;
                    end else if (sif.pin_valid) begin
                        if (sif.pin_ok) begin
                            state_q     <= ST_MENU;
                            timer_clr_q <= 1'b1;
                        end else if ((int'(tries_q) + 1) == MAX_TRIES) begin
                            state_q  <= ST_LOCK;
                            err_q    <= ERR_OVF_LOCK;
                            locked_q <= 1'b1;
                            eject_q  <= 1'b0;
                        end else begin
                            tries_q     <= tries_q + 3'd1;
                            timer_clr_q <= 1'b1;
                        end
                    end
                end
                ST_MENU: begin
                    if (!sif.card_in) begin
                        state_q <= ST_IDLE;
                        err_q   <= ERR_NONE;
                    end else if (sif.timeout) begin
                        state_q <= ST_EJECT;
                        err_q   <= ERR_TMO;
                        eject_q <= 1'b1;
                    end else if (sif.op_valid) begin
                        if (op_e'(sif.op_code) == OP_EXIT) begin
                            state_q <= ST_EJECT;
                            err_q   <= ERR_NONE;
                            eject_q <= 1'b1;
                        end else begin
                            state_q     <= ST_EXEC;
                            op_q        <= op_e'(sif.op_code);
                            amt_q       <= sif.amount;
                            timer_clr_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // timeout is deliberately not looked at: the timer is
                    // restarted in this same cycle.
                    if (!sif.card_in) begin
                        state_q <= ST_IDLE;
                        err_q   <= ERR_NONE;
                    end else begin
                        state_q       <= ST_MENU;
                        done_q        <= 1'b1;
                        timer_clr_q   <= 1'b1;
                        balance_we_q  <= calc_write_ok;
                        balance_out_q <= calc_balance;
                        err_q         <= calc_err;
                    end
                end
                ST_EJECT: begin
                    if (!sif.card_in) begin
                        state_q <= ST_IDLE;
                        eject_q <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    locked_q <= 1'b1;
                    eject_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sif.state_o     = state_q;
    assign sif.timer_clr   = timer_clr_q;
    assign sif.balance_we  = balance_we_q;
    assign sif.balance_out = balance_out_q;
    assign sif.done        = done_q;
    assign sif.err_code    = err_q;
    assign sif.eject       = eject_q;
    assign sif.card_locked = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
module tb_atm_session_ctrl;

    localparam int BAL_W     = 16;
    localparam int MAX_TRIES = 3;
    localparam int BAL_MAX   = (1 << BAL_W) - 1;

    localparam int S_IDLE = 0, S_PIN = 1, S_MENU = 2, S_EXEC = 3, S_EJECT = 4, S_LOCK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    atm_session_ctrl_if #(.BAL_W(BAL_W)) sif ();

    atm_session_ctrl #(.MAX_TRIES(MAX_TRIES), .BAL_W(BAL_W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference outcome of a transaction, from the account rules.
    function automatic int f_err(input int op, input int amt, input int bal);
        if (op == 1) return ((amt == 0) || (amt > bal)) ? 2 : 0;
        if (op == 2) begin
            if (amt == 0) return 2;
            if (amt + bal > BAL_MAX) return 3;
        end
        return 0;
    endfunction

    function automatic int f_we(input int op, input int amt, input int bal);
        return ((op == 1 || op == 2) && f_err(op, amt, bal) == 0) ? 1 : 0;
    endfunction

    function automatic int f_bout(input int op, input int amt, input int bal);
        if (f_we(op, amt, bal) == 0) return bal;
        return (op == 1) ? bal - amt : bal + amt;
    endfunction

    // Behavioural model
    int m_state = 0, m_tries = 0, m_op = 0, m_amt = 0;
    int m_tclr = 0, m_we = 0, m_bout = 0, m_done = 0, m_err = 0, m_eject = 0, m_lock = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= S_IDLE; m_tries <= 0; m_op <= 0; m_amt <= 0;
            m_tclr <= 0; m_we <= 0; m_bout <= 0; m_done <= 0;
            m_err <= 0; m_eject <= 0; m_lock <= 0;
        end else begin
            m_tclr <= 0; m_we <= 0; m_done <= 0; m_bout <= 0;
            if (m_state == S_IDLE) begin
                if (sif.card_in) begin
                    m_state <= S_PIN; m_tclr <= 1; m_tries <= 0; m_err <= 0;
                end
            end else if (m_state == S_PIN || m_state == S_MENU || m_state == S_EXEC) begin
                if (!sif.card_in) begin
                    m_state <= S_IDLE; m_err <= 0;
                end else if (m_state == S_EXEC) begin
                    m_state <= S_MENU; m_done <= 1; m_tclr <= 1;
                    m_we   <= f_we(m_op, m_amt, int'(sif.balance_in));
                    m_bout <= f_bout(m_op, m_amt, int'(sif.balance_in));
                    m_err  <= f_err(m_op, m_amt, int'(sif.balance_in));
                end else if (sif.timeout) begin
                    m_state <= S_EJECT; m_err <= 1; m_eject <= 1;
                end else if (m_state == S_PIN && sif.pin_valid) begin
                    if (sif.pin_ok) begin
                        m_state <= S_MENU; m_tclr <= 1;
                    end else if (m_tries + 1 == MAX_TRIES) begin
                        m_state <= S_LOCK; m_err <= 3; m_lock <= 1; m_eject <= 0;
                    end else begin
                        m_tries <= m_tries + 1; m_tclr <= 1;
                    end
                end else if (m_state == S_MENU && sif.op_valid) begin
                    if (sif.op_code == 2'b11) begin
                        m_state <= S_EJECT; m_err <= 0; m_eject <= 1;
                    end else begin
                        m_state <= S_EXEC; m_op <= int'(sif.op_code);
                        m_amt <= int'(sif.amount); m_tclr <= 1;
                    end
                end
            end else if (m_state == S_EJECT) begin
                if (!sif.card_in) begin
                    m_state <= S_IDLE; m_eject <= 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state_o",     int'(sif.state_o),     m_state);
            check("timer_clr",   int'(sif.timer_clr),   m_tclr);
            check("balance_we",  int'(sif.balance_we),  m_we);
            check("balance_out", int'(sif.balance_out), m_bout);
            check("done",        int'(sif.done),        m_done);
            check("err_code",    int'(sif.err_code),    m_err);
            check("eject",       int'(sif.eject),       m_eject);
            check("card_locked", int'(sif.card_locked), m_lock);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_pin(input logic ok);
        sif.pin_valid = 1'b1;
        sif.pin_ok    = ok;
        step();
        sif.pin_valid = 1'b0;
    endtask

    task automatic pulse_op(input logic [1:0] op, input int amt);
        sif.op_valid = 1'b1;
        sif.op_code  = op;
        sif.amount   = BAL_W'(amt);
        step();
        sif.op_valid = 1'b0;
    endtask

    initial begin
        sif.card_in    = 1'b0;
        sif.pin_valid  = 1'b0;
        sif.pin_ok     = 1'b0;
        sif.op_valid   = 1'b0;
        sif.op_code    = 2'b00;
        sif.amount     = '0;
        sif.balance_in = BAL_W'(1000);
        sif.timeout    = 1'b0;
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        check("reset_state", int'(sif.state_o), 0);
        check("reset_eject", int'(sif.eject), 0);
        check("reset_locked", int'(sif.card_locked), 0);
        check("reset_err", int'(sif.err_code), 0);

        // Withdraw 300 from 1000
        sif.card_in = 1'b1;
        step();
        check("t1_pin_state", int'(sif.state_o), 1);
        check("t1_pin_tclr", int'(sif.timer_clr), 1);
        pulse_pin(1'b1);
        check("t1_menu_state", int'(sif.state_o), 2);
        check("t1_menu_tclr", int'(sif.timer_clr), 1);
        pulse_op(2'b01, 300);
        check("t1_exec_state", int'(sif.state_o), 3);
        check("t1_exec_tclr", int'(sif.timer_clr), 1);
        check("t1_exec_nodone", int'(sif.done), 0);
        step();
        check("t1_done", int'(sif.done), 1);
        check("t1_we", int'(sif.balance_we), 1);
        check("t1_bout", int'(sif.balance_out), 700);
        check("t1_model_bout", m_bout, 700);
        check("t1_err", int'(sif.err_code), 0);
        check("t1_tclr", int'(sif.timer_clr), 1);
        check("t1_back_menu", int'(sif.state_o), 2);

        // Amount boundaries and query
        pulse_op(2'b01, 1001);
        step();
        check("t3_wdr_done", int'(sif.done), 1);
        check("t3_wdr_we", int'(sif.balance_we), 0);
        check("t3_wdr_err", int'(sif.err_code), 2);
        sif.balance_in = BAL_W'(16'hFFFF);
        pulse_op(2'b10, 2);
        step();
        check("t3_dep_err", int'(sif.err_code), 3);
        check("t3_dep_model_err", m_err, 3);
        check("t3_dep_we", int'(sif.balance_we), 0);
        check("t3_dep_done", int'(sif.done), 1);
        sif.balance_in = BAL_W'(1000);
        pulse_op(2'b00, 0);
        step();
        check("t3_qry_bout", int'(sif.balance_out), 1000);
        check("t3_qry_done", int'(sif.done), 1);
        check("t3_qry_we", int'(sif.balance_we), 0);
        check("t3_qry_err", int'(sif.err_code), 0);

        // Stray pin_valid in MENU, then exit
        pulse_pin(1'b1);
        check("t6_stray_pin", int'(sif.state_o), 2);
        pulse_op(2'b11, 0);
        check("t6_exit_state", int'(sif.state_o), 4);
        check("t6_exit_eject", int'(sif.eject), 1);
        check("t6_exit_err", int'(sif.err_code), 0);
        sif.card_in = 1'b0;
        step();
        check("t6_idle", int'(sif.state_o), 0);
        check("t6_eject_off", int'(sif.eject), 0);

        // Timeout beats op_valid in MENU
        sif.card_in = 1'b1;
        step();
        pulse_pin(1'b1);
        sif.timeout = 1'b1;
        pulse_op(2'b01, 5);
        sif.timeout = 1'b0;
        check("t4_eject_state", int'(sif.state_o), 4);
        check("t4_eject", int'(sif.eject), 1);
        check("t4_err", int'(sif.err_code), 1);
        step();
        check("t4_no_done", int'(sif.done), 0);
        check("t4_hold_eject", int'(sif.state_o), 4);
        sif.card_in = 1'b0;
        step();
        check("t4_idle", int'(sif.state_o), 0);
        check("t4_eject_off", int'(sif.eject), 0);
        check("t4_err_held", int'(sif.err_code), 1);
        sif.card_in = 1'b1;
        step();
        check("t4_pin", int'(sif.state_o), 1);
        check("t4_err_clr", int'(sif.err_code), 0);
        pulse_op(2'b01, 5);
        check("t6_stray_op", int'(sif.state_o), 1);
        pulse_pin(1'b1);
        check("t5_menu", int'(sif.state_o), 2);

        // Card removal in MENU, then reset in EXEC
        sif.card_in = 1'b0;
        step();
        check("t5_remove_idle", int'(sif.state_o), 0);
        check("t5_remove_done", int'(sif.done), 0);
        sif.card_in = 1'b1;
        step();
        pulse_pin(1'b1);
        pulse_op(2'b10, 10);
        check("t5_in_exec", int'(sif.state_o), 3);
        rst = 1'b0;
        #1;
        check("t5_rst_state", int'(sif.state_o), 0);
        check("t5_rst_tclr", int'(sif.timer_clr), 0);
        check("t5_rst_we", int'(sif.balance_we), 0);
        check("t5_rst_done", int'(sif.done), 0);
        step();
        check("t5_rst_we2", int'(sif.balance_we), 0);
        rst = 1'b1;

        // Lockout after MAX_TRIES wrong PINs
        step();
        check("t2_pin", int'(sif.state_o), 1);
        pulse_pin(1'b0);
        check("t2_try1_state", int'(sif.state_o), 1);
        check("t2_try1_tclr", int'(sif.timer_clr), 1);
        pulse_pin(1'b0);
        pulse_pin(1'b0);
        check("t2_lock_state", int'(sif.state_o), 5);
        check("t2_locked", int'(sif.card_locked), 1);
        check("t2_err", int'(sif.err_code), 3);
        check("t2_no_eject", int'(sif.eject), 0);
        sif.card_in   = 1'b0;
        sif.timeout   = 1'b1;
        sif.pin_valid = 1'b1;
        repeat (2) step();
        sif.timeout   = 1'b0;
        sif.pin_valid = 1'b0;
        check("t2_lock_held", int'(sif.state_o), 5);
        check("t2_locked_held", int'(sif.card_locked), 1);
        rst = 1'b0;
        step();
        check("t2_rst_state", int'(sif.state_o), 0);
        check("t2_rst_locked", int'(sif.card_locked), 0);
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (!rst) rst = 1'b1;
            else if ((m_lock != 0 && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0)
                rst = 1'b0;
            if (sif.card_in) sif.card_in = ($urandom_range(0, 39) != 0);
            else             sif.card_in = ($urandom_range(0, 3) == 0);
            sif.pin_valid = ($urandom_range(0, 2) == 0);
            sif.pin_ok    = ($urandom_range(0, 2) != 0);
            sif.op_valid  = ($urandom_range(0, 2) == 0);
            sif.op_code   = 2'($urandom_range(0, 3));
            sif.timeout   = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       sif.amount = '0;
                1:       sif.amount = BAL_W'($urandom_range(1, 50));
                2:       sif.amount = sif.balance_in + BAL_W'($urandom_range(0, 2)) - BAL_W'(1);
                default: sif.amount = BAL_W'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       sif.balance_in = BAL_W'(BAL_MAX - $urandom_range(0, 3));
                1:       sif.balance_in = BAL_W'($urandom_range(0, 100));
                default: sif.balance_in = BAL_W'($urandom);
            endcase
            step();
        end

        rst = 1'b1;
        step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Session controller for the ATM. It consumes the one-cycle `timeout` pulse from the inactivity timer and drives that timer's restart input. It sequences card insertion, PIN entry with retry lockout, menu selection and one-cycle transaction execution against the account balance. It sits between the keypad/card front end and the balance store, and is the direct consumer of the timer.

Parameters:
MAX_TRIES, 3, wrong-PIN attempts before the card is retained (1..7).
BAL_W, 16, balance/amount width in bits.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
card_in  input  1  level; card present in reader.
pin_valid  input  1  pulse; PIN entry complete.
pin_ok  input  1  PIN matches; qualified by pin_valid.
op_valid  input  1  pulse; menu selection made.
op_code  input  2  00 balance query, 01 withdraw, 10 deposit, 11 exit.
amount  input  BAL_W  transaction amount; sampled with op_valid.
balance_in  input  BAL_W  current account balance from balance store.
timeout  input  1  one-cycle inactivity pulse from timer.
timer_clr  output  1  one-cycle pulse; restarts timer (drives the timer's active-high rst).
state_o  output  3  current state encoding.
balance_we  output  1  one-cycle write strobe to balance store.
balance_out  output  BAL_W  new balance (valid with balance_we) or queried balance (valid with done).
done  output  1  one-cycle pulse; transaction finished.
err_code  output  2  00 none, 01 timeout, 10 insufficient/zero amount, 11 deposit overflow or lockout.
eject  output  1  level; return card.
card_locked  output  1  level; card retained.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE, tries=0.
  - All outputs 0.
- States: IDLE=0, PIN=1, MENU=2, EXEC=3, EJECT=4, LOCK=5.
- Priority in PIN/MENU/EXEC: card_in=0 first, then timeout, then pin_valid/op_valid.
- Card removal (card_in=0) in PIN/MENU/EXEC: go to IDLE next cycle. No balance_we, no done; err_code cleared.
- IDLE:
  - card_in=1: go to PIN, pulse timer_clr, tries=0, err_code=00.
- PIN:
  - timeout: go to EJECT, err_code=01.
  - pin_valid & pin_ok: go to MENU, pulse timer_clr.
  - pin_valid & !pin_ok, tries+1==MAX_TRIES: go to LOCK, err_code=11.
  - pin_valid & !pin_ok, otherwise: tries++, stay in PIN, pulse timer_clr.
- MENU:
  - timeout: go to EJECT, err_code=01.
  - op_valid & op_code=11: go to EJECT, err_code=00.
  - Other op_valid: latch op_code and amount, go to EXEC, pulse timer_clr.
- EXEC (exactly one cycle, then MENU):
  - Every outcome: done=1 and timer_clr=1 in the same cycle.
  - Query: balance_out=balance_in, err 00, no write.
  - Withdraw, amount==0 or amount>balance_in: err 10, no write.
  - Withdraw, otherwise: balance_we=1, balance_out=balance_in-amount, err 00.
  - Deposit, amount==0: err 10, no write.
  - Deposit, (BAL_W+1)-bit sum overflows: err 11, no write.
  - Deposit, otherwise: balance_we=1, balance_out=balance_in+amount.
  - timeout in EXEC is ignored (the timer is cleared the same cycle).
- EJECT:
  - eject=1.
  - Go to IDLE once card_in=0; eject drops on entry to IDLE.
  - err_code holds until next IDLE→PIN.
- LOCK:
  - card_locked=1, eject=0.
  - card_in, timeout and all strobes are ignored; exit only by reset.
- Latency:
  - op_valid to done/balance_we: 2 cycles (MENU→EXEC registered, outputs registered).
  - pin_valid to state change: 1 cycle.
- Strobes outside their states are ignored: pin_valid outside PIN, op_valid outside MENU.
- Reset mid-EXEC: no balance_we is produced.

Decomposition:
- Package atm_pkg holds:
  - state encodings;
  - op codes OP_BAL/OP_WDR/OP_DEP/OP_EXIT;
  - error codes ERR_NONE/ERR_TMO/ERR_AMT/ERR_OVF_LOCK.
- Sub-module atm_txn_calc: purely combinational. Takes op, amount and balance_in; produces new_balance, write_ok and err. Instantiated once; the FSM registers its results in EXEC.

Test Plan:
1. Insert card, pin_valid with pin_ok=1, op_valid op=01 amount=300, balance_in=1000 → balance_we pulse with balance_out=700, done, err 00, state back to MENU, timer_clr pulsed at PIN, MENU and EXEC.
2. MAX_TRIES=3: three pin_valid with pin_ok=0 → after 3rd, state=LOCK, card_locked=1, err 11. card_in drop and timeout ignored; only rst clears.
3. Withdraw 1001 from balance 1000 → err 10, done, no balance_we. Deposit 0x0002 onto 0xFFFF (BAL_W=16) → err 11, no write. Query → balance_out=1000, done, no write.
4. Timeout pulse in MENU coinciding with op_valid → EJECT, eject=1, err 01, no EXEC. Drop card_in → IDLE, eject=0.
5. Remove card in MENU → IDLE next cycle, no done. Assert rst=0 while in EXEC → all outputs 0 immediately, no balance_we.
6. op=11 in MENU → EJECT with err 00. Stray pin_valid in MENU and op_valid in PIN → no state change.
